// File: rtl/count_monitor.sv
// count_monitor: debounces a count bus coming from an asynchronous ripple
// counter. q_in passes through a two-flop synchronizer. A value is accepted
// only after STABLE consecutive identical synchronized samples. Each accepted
// change produces a one-cycle valid pulse. When valid pulses, wrap reports a
// decrease in the count and match reports equality with thresh. wrap_cnt is
// a saturating count of wrap events.
//
// STABLE must lie in 2..8.
module count_monitor #(
  parameter int WIDTH  = 4,
  parameter int STABLE = 2
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] q_in,
  input  logic             en,
  input  logic [WIDTH-1:0] thresh,
  input  logic             clear,
  output logic [WIDTH-1:0] q_stable,
  output logic             valid,
  output logic             wrap,
  output logic             match,
  output logic [7:0]       wrap_cnt
);

  localparam int RUN_W = $clog2(STABLE + 1);
  localparam logic [RUN_W-1:0] RUN_MAX = RUN_W'(STABLE);
  localparam logic [RUN_W-1:0] RUN_ONE = RUN_W'(1);

  logic [WIDTH-1:0] s1_q, s2_q;
  logic [WIDTH-1:0] cand_q, cand_d;
  logic [RUN_W-1:0] run_q, run_d;
  logic [WIDTH-1:0] q_stable_q, q_stable_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;
  logic             match_q, match_d;
  logic [7:0]       wrap_cnt_q, wrap_cnt_d;

  // Two-flop synchronizer for the asynchronous count; it keeps running while
  // en is low so filtering can resume from fresh samples.
  always_ff @(posedge clk) begin
    if (rst) begin
      s1_q <= '0;
      s2_q <= '0;
    end else begin
      s1_q <= q_in;
      s2_q <= s2_next();
    end
  end

  function automatic logic [WIDTH-1:0] s2_next();
    return s1_q;
  endfunction

  // Stability filter, acceptance and wrap counting. The run counter
  // saturates, so a value held for a long time is accepted at most once.
  always_comb begin
    cand_d     = cand_q;
    run_d      = run_q;
    q_stable_d = q_stable_q;
    valid_d    = 1'b0;
    wrap_d     = 1'b0;
    match_d    = 1'b0;
    wrap_cnt_d = wrap_cnt_q;

    if (en) begin
      if (s2_q != cand_q) begin
        cand_d = s2_q;
        run_d  = RUN_ONE;
      end else if (run_q != RUN_MAX) begin
        run_d = run_q + RUN_ONE;
        // Accept only on the edge where the run reaches STABLE, and only if
        // the value actually differs from the one already published.
        if ((run_q == RUN_MAX - RUN_ONE) && (cand_q != q_stable_q)) begin
          q_stable_d = cand_q;
          valid_d    = 1'b1;
          wrap_d     = (cand_q < q_stable_q);
          match_d    = (cand_q == thresh);
        end
      end
    end

    // clear wins over a simultaneous wrap; the wrap pulse itself is unaffected.
    if (clear) begin
      wrap_cnt_d = 8'd0;
    end else if (wrap_d && (wrap_cnt_q != 8'hFF)) begin
      wrap_cnt_d = wrap_cnt_q + 8'd1;
    end
  end

  // State and output registers; rst overrides en and clear.
  always_ff @(posedge clk) begin
    if (rst) begin
      cand_q     <= '0;
      run_q      <= '0;
      q_stable_q <= '0;
      valid_q    <= 1'b0;
      wrap_q     <= 1'b0;
      match_q    <= 1'b0;
      wrap_cnt_q <= 8'd0;
    end else begin
      cand_q     <= cand_d;
      run_q      <= run_d;
      q_stable_q <= q_stable_d;
      valid_q    <= valid_d;
      wrap_q     <= wrap_d;
      match_q    <= match_d;
      wrap_cnt_q <= wrap_cnt_d;
    end
  end

  assign q_stable = q_stable_q;
  assign valid    = valid_q;
  assign wrap     = wrap_q;
  assign match    = match_q;
  assign wrap_cnt = wrap_cnt_q;

endmodule

// File: tb/tb_count_monitor.sv
// Directed bench for count_monitor at default parameters (WIDTH=4, STABLE=2).
// Expected values are hand-derived from the 2+STABLE = 4 edge acceptance
// latency.
module tb_count_monitor;

  logic       clk;
  logic       rst;
  logic [3:0] q_in;
  logic       en;
  logic [3:0] thresh;
  logic       clear;
  logic [3:0] q_stable;
  logic       valid;
  logic       wrap;
  logic       match;
  logic [7:0] wrap_cnt;

  int checks   = 0;
  int failures = 0;
  int n_valid  = 0;
  int n_wrap   = 0;
  int n_match  = 0;
  int n_orphan = 0;
  int v0, w0, m0;

  count_monitor dut (
    .clk      (clk),
    .rst      (rst),
    .q_in     (q_in),
    .en       (en),
    .thresh   (thresh),
    .clear    (clear),
    .q_stable (q_stable),
    .valid    (valid),
    .wrap     (wrap),
    .match    (match),
    .wrap_cnt (wrap_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    if (obs !== exp) begin
      failures++;
      $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
    end
  endtask

  // Advance n rising edges, sampling 1ns after each and tallying pulses.
  task automatic step(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
      if (valid) n_valid++;
      if (wrap) n_wrap++;
      if (match) n_match++;
      if (match && !valid) n_orphan++;
    end
  endtask

  // One full 15 -> 0 cycle of the upstream count; the second half wraps.
  task automatic wrap_seq();
    q_in = 4'd15;
    step(5);
    q_in = 4'd0;
    step(5);
  endtask

  initial begin
    rst    = 1'b1;
    q_in   = 4'd0;
    en     = 1'b1;
    thresh = 4'd5;
    clear  = 1'b0;
    step(2);
    check("rst_q_stable", q_stable, 0);
    check("rst_valid", valid, 0);
    check("rst_wrap", wrap, 0);
    check("rst_match", match, 0);
    check("rst_wrap_cnt", wrap_cnt, 0);

    // Idle zero after reset never publishes.
    rst = 1'b0;
    v0 = n_valid;
    step(6);
    check("idle_zero_no_valid", n_valid - v0, 0);

    // First accepted value, matching thresh, on the 4th edge.
    q_in = 4'd5;
    step(3);
    check("lat_edge3_valid", valid, 0);
    check("lat_edge3_q_stable", q_stable, 0);
    step(1);
    check("accept5_valid", valid, 1);
    check("accept5_match", match, 1);
    check("accept5_wrap", wrap, 0);
    check("accept5_q_stable", q_stable, 5);
    step(1);
    check("accept5_pulse_end", valid, 0);
    check("accept5_match_end", match, 0);

    // 5 -> 2 is a decrease: wraps.
    q_in = 4'd2;
    step(4);
    check("accept2_valid", valid, 1);
    check("accept2_wrap", wrap, 1);
    check("accept2_match", match, 0);
    check("accept2_wrap_cnt", wrap_cnt, 1);
    step(2);

    // One-cycle glitch to 3 is rejected.
    v0 = n_valid;
    q_in = 4'd3;
    step(1);
    q_in = 4'd2;
    step(8);
    check("glitch_no_valid", n_valid - v0, 0);
    check("glitch_q_stable", q_stable, 2);

    // Go to 15, clear the counter, then 15 -> 0.
    q_in = 4'd15;
    step(4);
    check("accept15_q_stable", q_stable, 15);
    check("accept15_wrap", wrap, 0);
    step(2);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clear_wrap_cnt", wrap_cnt, 0);
    q_in = 4'd0;
    step(3);
    check("wrap0_pre_cnt", wrap_cnt, 0);
    step(1);
    check("wrap0_valid", valid, 1);
    check("wrap0_wrap", wrap, 1);
    check("wrap0_q_stable", q_stable, 0);
    check("wrap0_cnt", wrap_cnt, 1);
    step(1);
    check("wrap0_pulse_end", wrap, 0);

    // Build wrap_cnt up to 7, then clear on the same edge as a wrap.
    repeat (6) wrap_seq();
    check("cnt_seven", wrap_cnt, 7);
    q_in = 4'd15;
    step(5);
    q_in = 4'd0;
    step(3);
    clear = 1'b1;
    step(1);
    clear = 1'b0;
    check("clear_wrap_same_edge_cnt", wrap_cnt, 0);
    check("clear_wrap_same_edge_wrap", wrap, 1);
    check("clear_wrap_same_edge_valid", valid, 1);
    step(1);

    // Saturation after 260 wraps.
    w0 = n_wrap;
    v0 = n_valid;
    repeat (260) wrap_seq();
    check("sat_wrap_pulses", n_wrap - w0, 260);
    check("sat_valid_pulses", n_valid - v0, 520);
    check("sat_wrap_cnt", wrap_cnt, 255);
    wrap_seq();
    check("sat_hold_wrap_cnt", wrap_cnt, 255);

    // Enable gating: 4 accepted, then 9 arrives while disabled.
    q_in = 4'd4;
    step(6);
    check("accept4_q_stable", q_stable, 4);
    en = 1'b0;
    q_in = 4'd9;
    thresh = 4'd9;
    v0 = n_valid;
    step(10);
    check("en0_no_valid", n_valid - v0, 0);
    check("en0_q_stable", q_stable, 4);
    en = 1'b1;
    step(1);
    check("en1_edge1_valid", valid, 0);
    step(1);
    check("en1_edge2_valid", valid, 1);
    check("en1_q_stable", q_stable, 9);
    check("en1_match", match, 1);
    check("en1_wrap", wrap, 0);

    // Held value with thresh match: no further match pulses.
    m0 = n_match;
    step(10);
    check("held_no_match", n_match - m0, 0);

    // Reset mid-acceptance discards the pending candidate.
    q_in = 4'd3;
    step(3);
    rst = 1'b1;
    step(1);
    check("midrst_valid", valid, 0);
    check("midrst_q_stable", q_stable, 0);
    check("midrst_wrap_cnt", wrap_cnt, 0);
    rst = 1'b0;
    q_in = 4'd0;
    v0 = n_valid;
    step(6);
    check("midrst_no_valid_after", n_valid - v0, 0);
    check("midrst_q_stable_after", q_stable, 0);

    check("match_only_with_valid", n_orphan, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/count_monitor.md
COUNT_MONITOR -- requirements
Module: count_monitor

Interface
REQ-001 SHALL have parameter WIDTH, default 4: width of the sampled count bus.
REQ-002 SHALL have parameter STABLE, default 2: number of consecutive identical synchronized samples needed to accept a value. Legal range 2..8.
REQ-003 SHALL have port clk, input, 1: single clock; all state updates on its rising edge.
REQ-004 SHALL have port rst, input, 1: synchronous, active-high reset.
REQ-005 SHALL have port q_in, input, WIDTH: count from the upstream ripple D-FF up-counter; asynchronous to clk and may glitch.
REQ-006 SHALL have port en, input, 1: filter enable.
REQ-007 SHALL have port thresh, input, WIDTH: match value; static, or changed only while en=0.
REQ-008 SHALL have port clear, input, 1: synchronous clear of wrap_cnt.
REQ-009 SHALL have port q_stable, output, WIDTH: last accepted count value.
REQ-010 SHALL have port valid, output, 1: one-cycle pulse on each q_stable update.
REQ-011 SHALL have port wrap, output, 1: one-cycle pulse with valid when the new value is below the old one.
REQ-012 SHALL have port match, output, 1: one-cycle pulse with valid when the new value equals thresh.
REQ-013 SHALL have port wrap_cnt, output, 8: saturating count of wrap events.

Function
REQ-014 SHALL pass q_in through two flops, s1 then s2, every cycle regardless of en.
REQ-015 SHALL hold a candidate register cand (WIDTH bits) and a run counter run (0..STABLE, saturating).
REQ-016 When en=1 and s2!=cand, SHALL load cand<=s2 and set run<=1.
REQ-017 When en=1 and s2==cand, SHALL increment run, saturating at STABLE.
REQ-018 At the edge where run becomes STABLE (transition from STABLE-1), if cand!=q_stable, SHALL load q_stable<=cand and register valid=1 for exactly one cycle.
REQ-019 SHALL NOT update q_stable or pulse valid when the accepted cand equals q_stable, or while run stays saturated.
REQ-020 Latency from a q_in step held steady to the q_stable update SHALL be 2+STABLE rising edges (4 at the default).
REQ-021 SHALL register wrap=1 together with valid when cand < old q_stable (unsigned); this covers 15->0 and skipped-value wraps.
REQ-022 SHALL register match=1 together with valid when cand==thresh; match SHALL NOT fire without valid.
REQ-023 SHALL increment wrap_cnt by 1 on each wrap, saturating at 255 (no rollover).
REQ-024 When clear=1, SHALL set wrap_cnt<=0; if clear and a wrap update occur on the same edge, wrap_cnt SHALL be 0 and the wrap pulse SHALL still assert.
REQ-025 When en=0, SHALL hold cand and run, and force valid, wrap and match to 0. The synchronizer keeps running, so filtering resumes from the held cand/run state when en returns to 1.
REQ-026 Any input change shorter than STABLE consecutive s2 samples SHALL be rejected, with no output change.
REQ-027 All outputs SHALL be driven directly from flops.

Reset
REQ-028 When rst=1, on the next edge SHALL clear s1, s2, cand, run, q_stable, wrap_cnt, valid, wrap and match to 0. rst takes priority over en and clear.
REQ-029 Reset asserted mid-acceptance SHALL discard the pending candidate; no valid pulse follows the reset edge.
REQ-030 After reset with q_in=0 held, SHALL produce no valid pulse, because cand equals q_stable.

Verification
REQ-031 Reset release, q_in=5, thresh=5, en=1 -> q_stable=5, valid=1, match=1 after the 4th edge; wrap=0.
REQ-032 q_stable=2; q_in=3 for one cycle, then back to 2 -> no valid pulse; q_stable stays 2.
REQ-033 q_stable=15; q_in=0 held -> valid=1, wrap=1, wrap_cnt 0->1 on the same edge.
REQ-034 Drive 260 wrap sequences (15->0) -> wrap_cnt=255 and stays there; wrap still pulses each time.
REQ-035 clear=1 on the same edge as a wrap update with wrap_cnt=7 -> wrap_cnt=0, wrap=1.
REQ-036 en=0, q_in 4->9 held for 10 cycles -> no valid; en=1 -> q_stable=9 with valid after 2 edges (cand resync plus run), i.e. STABLE edges.
